mesochronous_fifo: RTL and testbench

- Flow-controlled buffer carrying a valid/ready stream between two clock domains with identical frequency and a fixed, unknown phase offset.
- Write side accepts words on wrclk_i; read side presents them show-ahead on rdclk_i.
- Pointers cross domains Gray-coded. Flow control is available in both directions: wrready_o back-pressures the producer, rdready_i back-pressures the buffer.
- Used wherever the SDRAM controller moves command/data streams between the AHB clock and the phase-shifted SDRAM clock.

---
 rtl/mesochronous_fifo.sv | 162 ++++++++++++++++
 tb/tb_mesochronous_fifo.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesochronous_fifo.sv
// mesochronous_fifo: valid/ready FIFO between two equal-frequency clocks.
// Gray pointers cross domains; optional macro MESOCHRONOUS_FIFO_DUAL_SYNC_EN.
//
// Ports:
//   wrclk_i   / wrrst_ni  : write clock, async active-low write reset
//   rdclk_i   / rdrst_ni  : read clock, async active-low read reset
//   wrvalid_i / wrready_o : producer handshake (wrready_o = not full)
//   d_i                   : write data
//   rdvalid_o / rdready_i : consumer handshake (rdvalid_o = not empty)
//   q_o                   : show-ahead read data
//
// Build option:
//   MESOCHRONOUS_FIFO_DUAL_SYNC_EN undefined : one flop per crossing.
//   MESOCHRONOUS_FIFO_DUAL_SYNC_EN defined   : two flops per crossing,
//     tolerant of phase drift; full rate then needs DEPTH >= 8.

module mesochronous_fifo #(
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 4
) (
    input  logic                 wrclk_i,
    input  logic                 wrrst_ni,
    input  logic                 rdclk_i,
    input  logic                 rdrst_ni,
    input  logic                 wrvalid_i,
    output logic                 wrready_o,
    input  logic [DATA_SIZE-1:0] d_i,
    output logic                 rdvalid_o,
    input  logic                 rdready_i,
    output logic [DATA_SIZE-1:0] q_o
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // storage, written in the write domain only, never reset
    logic [DATA_SIZE-1:0] r_mem [DEPTH];

    // write-domain state
    ptr_t r_wrbin;
    ptr_t r_wrgray;
    ptr_t r_rdgray_wr;

    // read-domain state
    ptr_t r_rdbin;
    ptr_t r_rdgray;
    ptr_t r_wrgray_rd;

    ptr_t w_wrbin_nxt;
    ptr_t w_rdbin_nxt;
    ptr_t w_rdgray_full;
    logic w_full;
    logic w_empty;
    logic w_wr_en;
    logic w_rd_en;

    //------------------------------------------------------------
    // Write domain
    //------------------------------------------------------------

    // Full when the write pointer is exactly one lap ahead of the
    // (delayed) read pointer: in Gray form the top two bits differ.
    assign w_rdgray_full = {~r_rdgray_wr[AW:AW-1],
                            r_rdgray_wr[AW-2:0]};
    assign w_full        = (r_wrgray == w_rdgray_full);
    assign wrready_o     = ~w_full;

    assign w_wr_en     = wrvalid_i & ~w_full & wrrst_ni;
    assign w_wrbin_nxt = r_wrbin + ptr_t'(1);

    always_ff @(posedge wrclk_i or negedge wrrst_ni) begin
        if (!wrrst_ni) begin
            r_wrbin  <= '0;
            r_wrgray <= '0;
        end else if (w_wr_en) begin
            r_wrbin  <= w_wrbin_nxt;
            r_wrgray <= bin2gray(w_wrbin_nxt);
        end
    end

    always_ff @(posedge wrclk_i) begin
        if (w_wr_en) begin
            r_mem[r_wrbin[AW-1:0]] <= d_i;
        end
    end

    //------------------------------------------------------------
    // Read domain
    //------------------------------------------------------------

    assign w_empty   = (r_rdgray == r_wrgray_rd);
    assign rdvalid_o = ~w_empty;

    assign w_rd_en     = rdready_i & ~w_empty & rdrst_ni;
    assign w_rdbin_nxt = r_rdbin + ptr_t'(1);

    always_ff @(posedge rdclk_i or negedge rdrst_ni) begin
        if (!rdrst_ni) begin
            r_rdbin  <= '0;
            r_rdgray <= '0;
        end else if (w_rd_en) begin
            r_rdbin  <= w_rdbin_nxt;
            r_rdgray <= bin2gray(w_rdbin_nxt);
        end
    end

    // show-ahead: head entry straight from storage
    assign q_o = r_mem[r_rdbin[AW-1:0]];

    //------------------------------------------------------------
    // Pointer crossings
    //------------------------------------------------------------
    // Only one Gray bit moves per source cycle, so any sample is
    // either the old or the new pointer; both flags stay safe.

`ifdef MESOCHRONOUS_FIFO_DUAL_SYNC_EN
    ptr_t r_rdgray_meta;
    ptr_t r_wrgray_meta;

    always_ff @(posedge wrclk_i or negedge wrrst_ni) begin
        if (!wrrst_ni) begin
            r_rdgray_meta <= '0;
            r_rdgray_wr   <= '0;
        end else begin
            r_rdgray_meta <= r_rdgray;
            r_rdgray_wr   <= r_rdgray_meta;
        end
    end

    always_ff @(posedge rdclk_i or negedge rdrst_ni) begin
        if (!rdrst_ni) begin
            r_wrgray_meta <= '0;
            r_wrgray_rd   <= '0;
        end else begin
            r_wrgray_meta <= r_wrgray;
            r_wrgray_rd   <= r_wrgray_meta;
        end
    end
`else
    always_ff @(posedge wrclk_i or negedge wrrst_ni) begin
        if (!wrrst_ni) begin
            r_rdgray_wr <= '0;
        end else begin
            r_rdgray_wr <= r_rdgray;
        end
    end

    always_ff @(posedge rdclk_i or negedge rdrst_ni) begin
        if (!rdrst_ni) begin
            r_wrgray_rd <= '0;
        end else begin
            r_wrgray_rd <= r_wrgray;
        end
    end
`endif

endmodule

// File: tb/tb_mesochronous_fifo.sv
// tb_mesochronous_fifo: directed + random bench for mesochronous_fifo.
// Reference model is a plain queue of accepted words.
`timescale 1ns/1ps

module tb_mesochronous_fifo;

`ifdef MESOCHRONOUS_FIFO_DUAL_SYNC_EN
    localparam int DEPTH   = 8;
    localparam int LAT_MAX = 3;
`else
    localparam int DEPTH   = 4;
    localparam int LAT_MAX = 2;
`endif
    localparam int DW = 32;
    localparam int AW = $clog2(DEPTH);

    logic          wrclk   = 1'b0;
    logic          rdclk   = 1'b0;
    logic          wrrst_n = 1'b0;
    logic          rdrst_n = 1'b0;
    logic          wrvalid = 1'b0;
    logic          rdready = 1'b0;
    logic [DW-1:0] d       = '0;
    logic          wrready;
    logic          rdvalid;
    logic [DW-1:0] q;

    int vecs = 0;
    int errs = 0;
    int rd_shift = 0;

    logic [DW-1:0] mdl[$];
    logic [DW-1:0] last_q = '0;
    int  rd_count = 0;
    int  gaps     = 0;
    int  gap_lim  = 0;
    int  rd_edges = 0;
    int  wr_edges = 0;
    logic seen_v     = 1'b0;
    logic wr_started = 1'b0;

    logic [AW:0] wg_prev = '0;
    logic [AW:0] rg_prev = '0;
    logic        wg_ok   = 1'b0;
    logic        rg_ok   = 1'b0;

    mesochronous_fifo #(
        .DATA_SIZE(DW),
        .DEPTH    (DEPTH)
    ) dut (
        .wrclk_i  (wrclk),
        .wrrst_ni (wrrst_n),
        .rdclk_i  (rdclk),
        .rdrst_ni (rdrst_n),
        .wrvalid_i(wrvalid),
        .wrready_o(wrready),
        .d_i      (d),
        .rdvalid_o(rdvalid),
        .rdready_i(rdready),
        .q_o      (q)
    );

    // wrclk rises at 5+10k; rdclk lags by 1 ns, stretched on request
    always #5 wrclk = ~wrclk;

    initial begin
        #6;
        forever begin
            rdclk = 1'b1;
            #5;
            rdclk = 1'b0;
            #(5 + rd_shift);
            rd_shift = 0;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    always @(posedge wrclk) wr_edges++;

    always @(posedge rdclk) begin
        if (wr_started && !seen_v) rd_edges++;
    end

    // read-side monitor: model check of every word taken
    always @(negedge rdclk) begin
        logic [DW-1:0] exp_w;
        #2;
        if (rdrst_n && rdvalid) begin
            check("rd_nonempty", 32'(mdl.size() > 0), 32'd1);
            seen_v = 1'b1;
            if (rdready && mdl.size() > 0) begin
                exp_w = mdl.pop_front();
                check("rd_data", q, exp_w);
                last_q = q;
                rd_count++;
            end
        end else if (rdrst_n && seen_v && rd_count < gap_lim) begin
            gaps++;
        end
    end

    always @(posedge wrclk) begin
        assert (wrrst_n === rdrst_n) else begin
            errs++;
            $error("FAIL reset_pair: wr %b rd %b", wrrst_n, rdrst_n);
        end
    end

    always @(posedge wrclk) begin
        #1;
        if (wrrst_n && wg_ok)
            check("wr_gray_step",
                  32'($countones(dut.r_wrgray ^ wg_prev) <= 1), 32'd1);
        wg_prev = dut.r_wrgray;
        wg_ok   = wrrst_n;
    end

    always @(posedge rdclk) begin
        #1;
        if (rdrst_n && rg_ok)
            check("rd_gray_step",
                  32'($countones(dut.r_rdgray ^ rg_prev) <= 1), 32'd1);
        rg_prev = dut.r_rdgray;
        rg_ok   = rdrst_n;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input int shift);
        @(negedge wrclk);
        wrvalid = 1'b0;
        rdready = 1'b0;
        wrrst_n = 1'b0;
        rdrst_n = 1'b0;
        mdl.delete();
        rd_shift = shift;
        repeat (3) @(negedge wrclk);
        #2;
        wrrst_n = 1'b1;
        rdrst_n = 1'b1;
    endtask

    task automatic push_if_taken();
        if (wrvalid && wrready) begin
            check("wr_not_full", 32'(mdl.size() < DEPTH), 32'd1);
            mdl.push_back(d);
        end
    endtask

    task automatic stream_test(input int shift);
        int n;
        do_reset(shift);
        gap_lim    = 64;
        rd_count   = 0;
        gaps       = 0;
        rd_edges   = 0;
        seen_v     = 1'b0;
        wr_started = 1'b0;
        @(negedge rdclk);
        rdready = 1'b1;
        n = 1;
        for (int i = 0; i < 400 && n <= 64; i++) begin
            @(negedge wrclk);
            wrvalid = 1'b1;
            d = DW'(n);
            if (wrready) begin
                push_if_taken();
                n++;
                if (n == 2) begin
                    @(posedge wrclk);
                    wr_started = 1'b1;
                end
            end
        end
        @(negedge wrclk);
        wrvalid = 1'b0;
        for (int i = 0; i < 100 && rd_count < 64; i++)
            @(negedge wrclk);
        check("stream_count", 32'(rd_count), 32'd64);
        check("stream_gaps", 32'(gaps), 32'd0);
        check("stream_lat",
              32'(rd_edges >= 1 && rd_edges <= LAT_MAX), 32'd1);
        check("stream_empty", 32'(mdl.size()), 32'd0);
        gap_lim = 0;
    endtask

    initial begin
        int n;
        int e0;
        int lat;
        int base;

        // reset and idle
        do_reset(0);
        for (int i = 0; i < 10; i++) begin
            @(negedge rdclk);
            #1;
            check("idle_wrready", 32'(wrready), 32'd1);
            check("idle_rdvalid", 32'(rdvalid), 32'd0);
        end

        // streaming at 10%, 50%, 90% lag
        stream_test(0);
        stream_test(4);
        stream_test(4);

        // fill until full with reads stalled
        do_reset(0);
        n = 0;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            @(negedge wrclk);
            if (n == DEPTH)
                check("fill_full", 32'(wrready), 32'd0);
            wrvalid = 1'b1;
            d = 32'hA0 + DW'(n);
            if (wrready) begin
                push_if_taken();
                n++;
            end
        end
        check("fill_accepted", 32'(n), 32'(DEPTH));
        base = rd_count;
        @(negedge rdclk);
        rdready = 1'b1;
        @(posedge rdclk);
        e0  = wr_edges;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge wrclk);
            if (lat < 0 && wrready) lat = wr_edges - e0;
            wrvalid = (n < DEPTH + 1);
            d = 32'hA0 + DW'(n);
            if (wrvalid && wrready) begin
                push_if_taken();
                n++;
            end
        end
        wrvalid = 1'b0;
        check("free_lat", 32'(lat >= 1 && lat <= LAT_MAX), 32'd1);
        check("drain_count", 32'(rd_count - base), 32'(DEPTH + 1));
        check("next_word", last_q, 32'hA0 + 32'(DEPTH));

        // random traffic
        fork
            for (int i = 0; i < 10000; i++) begin
                @(negedge wrclk);
                wrvalid = 1'($urandom_range(0, 1));
                d = $urandom;
                push_if_taken();
            end
            for (int i = 0; i < 10000; i++) begin
                @(negedge rdclk);
                rdready = 1'($urandom_range(0, 1));
            end
        join
        @(negedge wrclk);
        wrvalid = 1'b0;
        @(negedge rdclk);
        rdready = 1'b1;
        for (int i = 0; i < 200 && mdl.size() > 0; i++)
            @(negedge rdclk);
        repeat (4) @(negedge rdclk);
        #1;
        check("rand_drained", 32'(mdl.size()), 32'd0);
        check("rand_rdvalid", 32'(rdvalid), 32'd0);

        // reset with three words held
        do_reset(0);
        for (int i = 0; i < 3; i++) begin
            @(negedge wrclk);
            wrvalid = 1'b1;
            d = 32'h1000 + DW'(i);
            push_if_taken();
        end
        @(negedge wrclk);
        wrvalid = 1'b0;
        repeat (4) @(negedge rdclk);
        #1;
        check("held_rdvalid", 32'(rdvalid), 32'd1);
        do_reset(0);
        @(negedge wrclk);
        check("rst_wrready", 32'(wrready), 32'd1);
        @(negedge rdclk);
        #1;
        check("rst_rdvalid", 32'(rdvalid), 32'd0);
        base = rd_count;
        @(negedge wrclk);
        wrvalid = 1'b1;
        d = 32'h5A5A_5A5A;
        push_if_taken();
        @(negedge wrclk);
        wrvalid = 1'b0;
        @(negedge rdclk);
        rdready = 1'b1;
        for (int i = 0; i < 20 && rd_count == base; i++)
            @(negedge rdclk);
        #3;
        check("rst_first_cnt", 32'(rd_count - base), 32'd1);
        check("rst_first_word", last_q, 32'h5A5A_5A5A);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
